ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline: operand forwarding muxes, ALU-source mux, ALU with funct decode, and destination-register select.
- Sits between the ID/EX and EX/MEM boundaries.
- All outputs are registered and form the EX/MEM pipeline register, with one-cycle latency.

---
 rtl/ex_stage_if.sv | 42 ++++
 rtl/ex_stage.sv | 114 +++++++++++
 tb/tb_ex_stage.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// EX-stage bundle: ID/EX control and operands in, EX/MEM pipeline register out.
// master drives the ID/EX side; slave is the execute stage itself.
interface ex_stage_if #(
   parameter int NB_REG  = 32,
   parameter int NB_ADDR = 5,
   parameter int ALU_OP  = 4
);
   logic               i_alu_src_CU;
   logic               i_reg_dst_CU;
   logic               i_jal_sel_CU;
   logic [ALU_OP-1:0]  i_alu_op_CU;
   logic [NB_REG-1:0]  i_rs_data;
   logic [NB_REG-1:0]  i_rt_data;
   logic [NB_ADDR-1:0] i_rd_from_ID;
   logic [NB_ADDR-1:0] i_rt_from_ID;
   logic [NB_REG-1:0]  i_inst_sign_extended;
   logic [NB_REG-1:0]  i_aluResult_WB;
   logic [NB_REG-1:0]  i_aluResult_MEM;
   logic [5:0]         i_op_r_tipe;
   logic [1:0]         i_forwardA;
   logic [1:0]         i_forwardB;
   logic [NB_REG-1:0]  o_alu_result;
   logic [NB_ADDR-1:0] o_write_reg;
   logic [NB_REG-1:0]  o_rd_to_WB;
   logic               o_alu_condition_zero;

   modport master (
      output i_alu_src_CU, i_reg_dst_CU, i_jal_sel_CU, i_alu_op_CU,
      output i_rs_data, i_rt_data, i_rd_from_ID, i_rt_from_ID,
      output i_inst_sign_extended, i_aluResult_WB, i_aluResult_MEM,
      output i_op_r_tipe, i_forwardA, i_forwardB,
      input  o_alu_result, o_write_reg, o_rd_to_WB, o_alu_condition_zero
   );

   modport slave (
      input  i_alu_src_CU, i_reg_dst_CU, i_jal_sel_CU, i_alu_op_CU,
      input  i_rs_data, i_rt_data, i_rd_from_ID, i_rt_from_ID,
      input  i_inst_sign_extended, i_aluResult_WB, i_aluResult_MEM,
      input  i_op_r_tipe, i_forwardA, i_forwardB,
      output o_alu_result, o_write_reg, o_rd_to_WB, o_alu_condition_zero
   );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU-source mux, ALU, destination select, EX/MEM register.
// Define EX_FORWARDING_EN to honour i_forwardA/i_forwardB; otherwise operands come from the register file.
module ex_stage #(
   parameter int NB_REG  = 32,
   parameter int NB_ADDR = 5,
   parameter int ALU_OP  = 4
) (
   input logic     i_clk,
   input logic     i_rst,
   ex_stage_if.slave bus
);
   logic [NB_REG-1:0]  w_op_a;
   logic [NB_REG-1:0]  w_fwd_b;
   logic [NB_REG-1:0]  w_op_b;
   logic [4:0]         w_shamt;
   logic [NB_REG-1:0]  w_alu_res;
   logic [NB_ADDR-1:0] w_write_reg;

   logic [NB_REG-1:0]  r_alu_result;
   logic [NB_ADDR-1:0] r_write_reg;
   logic [NB_REG-1:0]  r_rd_to_wb;
   logic               r_zero;

`ifdef EX_FORWARDING_EN
   // Forwarding muxes: 01 takes MEM, 10 takes WB, 00/11 keep register-file data
   always_comb begin
      w_op_a  = bus.i_rs_data;
      w_fwd_b = bus.i_rt_data;
      case (bus.i_forwardA)
         2'b01:   w_op_a = bus.i_aluResult_MEM;
         2'b10:   w_op_a = bus.i_aluResult_WB;
         default: w_op_a = bus.i_rs_data;
      endcase
      case (bus.i_forwardB)
         2'b01:   w_fwd_b = bus.i_aluResult_MEM;
         2'b10:   w_fwd_b = bus.i_aluResult_WB;
         default: w_fwd_b = bus.i_rt_data;
      endcase
   end
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^{bus.i_forwardA, bus.i_forwardB, bus.i_aluResult_MEM, bus.i_aluResult_WB};
   assign w_op_a  = bus.i_rs_data;
   assign w_fwd_b = bus.i_rt_data;
`endif

   assign w_op_b  = bus.i_alu_src_CU ? bus.i_inst_sign_extended : w_fwd_b;
   assign w_shamt = bus.i_inst_sign_extended[10:6];

   // ALU: control opcode first, R-type falls through to the funct decode
   always_comb begin
      w_alu_res = {NB_REG{1'b0}};
      case (bus.i_alu_op_CU)
         4'b0000: w_alu_res = w_op_a + w_op_b;
         4'b0001: w_alu_res = w_op_a - w_op_b;
         4'b0010: begin
            case (bus.i_op_r_tipe)
               6'b100000, 6'b100001: w_alu_res = w_op_a + w_op_b;
               6'b100010, 6'b100011: w_alu_res = w_op_a - w_op_b;
               6'b100100: w_alu_res = w_op_a & w_op_b;
               6'b100101: w_alu_res = w_op_a | w_op_b;
               6'b100110: w_alu_res = w_op_a ^ w_op_b;
               6'b100111: w_alu_res = ~(w_op_a | w_op_b);
               6'b101010: w_alu_res = {{(NB_REG-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
               6'b101011: w_alu_res = {{(NB_REG-1){1'b0}}, (w_op_a < w_op_b)};
               6'b000000: w_alu_res = w_op_b << w_shamt;
               6'b000010: w_alu_res = w_op_b >> w_shamt;
               6'b000011: w_alu_res = $signed(w_op_b) >>> w_shamt;
               6'b000100: w_alu_res = w_op_b << w_op_a[4:0];
               6'b000110: w_alu_res = w_op_b >> w_op_a[4:0];
               6'b000111: w_alu_res = $signed(w_op_b) >>> w_op_a[4:0];
               default:   w_alu_res = {NB_REG{1'b0}};
            endcase
         end
         4'b0011: w_alu_res = w_op_a & w_op_b;
         4'b0100: w_alu_res = w_op_a | w_op_b;
         4'b0101: w_alu_res = w_op_a ^ w_op_b;
         4'b0110: w_alu_res = w_op_b << 5'd16;
         4'b0111: w_alu_res = {{(NB_REG-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
         4'b1000: w_alu_res = {{(NB_REG-1){1'b0}}, (w_op_a < w_op_b)};
         default: w_alu_res = {NB_REG{1'b0}};
      endcase
   end

   // Destination register: jal forces $ra ahead of the rd/rt choice
   always_comb begin
      if (bus.i_jal_sel_CU)
         w_write_reg = NB_ADDR'(5'd31);
      else if (bus.i_reg_dst_CU)
         w_write_reg = bus.i_rd_from_ID;
      else
         w_write_reg = bus.i_rt_from_ID;
   end

   // EX/MEM pipeline register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_alu_result <= {NB_REG{1'b0}};
         r_write_reg  <= {NB_ADDR{1'b0}};
         r_rd_to_wb   <= {NB_REG{1'b0}};
         r_zero       <= 1'b0;
      end else begin
         r_alu_result <= w_alu_res;
         r_write_reg  <= w_write_reg;
         r_rd_to_wb   <= w_fwd_b;
         r_zero       <= (w_alu_res == {NB_REG{1'b0}});
      end
   end

   assign bus.o_alu_result         = r_alu_result;
   assign bus.o_write_reg          = r_write_reg;
   assign bus.o_rd_to_WB           = r_rd_to_wb;
   assign bus.o_alu_condition_zero = r_zero;
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: reference results queued at drive time, compared one edge later.
module tb_ex_stage;
   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  wr;
      logic [31:0] st;
      logic        z;
   } exp_t;

   logic i_clk = 1'b0;
   logic i_rst = 1'b0;
   ex_stage_if u_if ();
   exp_t sb_q[$];
   int n_cmp = 0;
   int n_err = 0;
   logic [5:0] functs [16];

   ex_stage u_dut (.i_clk(i_clk), .i_rst(i_rst), .bus(u_if));

   always #5 i_clk = ~i_clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [5:0] fn,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sh);
      logic [31:0] r;
      r = 32'd0;
      if (op == 4'd0) r = a + b;
      else if (op == 4'd1) r = a - b;
      else if (op == 4'd3) r = a & b;
      else if (op == 4'd4) r = a | b;
      else if (op == 4'd5) r = a ^ b;
      else if (op == 4'd6) r = {b[15:0], 16'h0000};
      else if (op == 4'd7) r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      else if (op == 4'd8) r = {31'd0, (a < b)};
      else if (op == 4'd2) begin
         if (fn == 6'h20 || fn == 6'h21) r = a + b;
         else if (fn == 6'h22 || fn == 6'h23) r = a - b;
         else if (fn == 6'h24) r = a & b;
         else if (fn == 6'h25) r = a | b;
         else if (fn == 6'h26) r = a ^ b;
         else if (fn == 6'h27) r = ~(a | b);
         else if (fn == 6'h2A) r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
         else if (fn == 6'h2B) r = {31'd0, (a < b)};
         else if (fn == 6'h00) r = b << sh;
         else if (fn == 6'h02) r = b >> sh;
         else if (fn == 6'h03) r = 32'($signed(b) >>> sh);
         else if (fn == 6'h04) r = b << a[4:0];
         else if (fn == 6'h06) r = b >> a[4:0];
         else if (fn == 6'h07) r = 32'($signed(b) >>> a[4:0]);
      end
      return r;
   endfunction

   task automatic drive(input logic src, input logic rdst, input logic jal, input logic [3:0] op,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd,
                        input logic [4:0] rtf, input logic [31:0] imm, input logic [31:0] wb,
                        input logic [31:0] mem, input logic [5:0] fn, input logic [1:0] fa,
                        input logic [1:0] fb);
      logic [31:0] a, bf, b;
      exp_t e;
      @(negedge i_clk);
      u_if.i_alu_src_CU = src;   u_if.i_reg_dst_CU = rdst;  u_if.i_jal_sel_CU = jal;
      u_if.i_alu_op_CU = op;     u_if.i_rs_data = rs;       u_if.i_rt_data = rt;
      u_if.i_rd_from_ID = rd;    u_if.i_rt_from_ID = rtf;   u_if.i_inst_sign_extended = imm;
      u_if.i_aluResult_WB = wb;  u_if.i_aluResult_MEM = mem; u_if.i_op_r_tipe = fn;
      u_if.i_forwardA = fa;      u_if.i_forwardB = fb;
      a = rs;
      bf = rt;
`ifdef EX_FORWARDING_EN
      if (fa == 2'b01) a = mem; else if (fa == 2'b10) a = wb;
      if (fb == 2'b01) bf = mem; else if (fb == 2'b10) bf = wb;
`endif
      b = src ? imm : bf;
      e.res = ref_alu(op, fn, a, b, imm[10:6]);
      e.wr  = jal ? 5'd31 : (rdst ? rd : rtf);
      e.st  = bf;
      e.z   = (e.res == 32'd0);
      sb_q.push_back(e);
   endtask

   task automatic step(input string tag);
      exp_t e;
      @(posedge i_clk);
      #1;
      if (sb_q.size() == 0) begin
         check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check_val({tag, "_res"}, u_if.o_alu_result, e.res);
         check_val({tag, "_wr"}, {27'd0, u_if.o_write_reg}, {27'd0, e.wr});
         check_val({tag, "_st"}, u_if.o_rd_to_WB, e.st);
         check_val({tag, "_z"}, {31'd0, u_if.o_alu_condition_zero}, {31'd0, e.z});
      end
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_res"}, u_if.o_alu_result, 32'd0);
      check_val({tag, "_wr"}, {27'd0, u_if.o_write_reg}, 32'd0);
      check_val({tag, "_st"}, u_if.o_rd_to_WB, 32'd0);
      check_val({tag, "_z"}, {31'd0, u_if.o_alu_condition_zero}, 32'd0);
   endtask

   initial begin
      functs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h07, 6'h3F};
      u_if.i_alu_src_CU = 1'b0;  u_if.i_reg_dst_CU = 1'b0;  u_if.i_jal_sel_CU = 1'b0;
      u_if.i_alu_op_CU = 4'd0;   u_if.i_rs_data = 32'd0;    u_if.i_rt_data = 32'd0;
      u_if.i_rd_from_ID = 5'd0;  u_if.i_rt_from_ID = 5'd0;  u_if.i_inst_sign_extended = 32'd0;
      u_if.i_aluResult_WB = 32'd0; u_if.i_aluResult_MEM = 32'd0; u_if.i_op_r_tipe = 6'd0;
      u_if.i_forwardA = 2'd0;    u_if.i_forwardB = 2'd0;
      #2 i_rst = 1'b1;
      #1 check_zero("rst_async");
      u_if.i_rs_data = 32'h55; u_if.i_rt_data = 32'h66;
      repeat (2) @(posedge i_clk);
      #1 check_zero("rst_held");
      @(negedge i_clk);
      i_rst = 1'b0;

      // src rdst jal op rs rt rd rtf imm wb mem funct fa fb
      drive(0, 0, 0, 4'd0, 32'h10, 32'h20, 5'd1, 5'd2, 32'h0,   32'h0,  32'h0,  6'h00, 2'b00, 2'b00); step("add");
      drive(0, 0, 0, 4'd0, 32'h10, 32'h20, 5'd1, 5'd2, 32'h0,   32'h0,  32'h30, 6'h00, 2'b01, 2'b00); step("fwdA_mem");
      drive(0, 0, 0, 4'd0, 32'h10, 32'h20, 5'd1, 5'd2, 32'h0,   32'h40, 32'h30, 6'h00, 2'b01, 2'b10); step("fwdB_wb");
      drive(1, 0, 0, 4'd0, 32'h10, 32'h20, 5'd1, 5'd2, 32'h4,   32'h40, 32'h30, 6'h00, 2'b01, 2'b10); step("imm");
      drive(1, 1, 1, 4'd0, 32'h10, 32'h20, 5'd1, 5'd2, 32'h4,   32'h40, 32'h30, 6'h00, 2'b01, 2'b10); step("jal");
      drive(1, 1, 0, 4'd0, 32'h10, 32'h20, 5'd1, 5'd2, 32'h4,   32'h40, 32'h30, 6'h00, 2'b01, 2'b10); step("rd");
      drive(0, 0, 0, 4'd2, 32'h50, 32'h60, 5'd1, 5'd3, 32'h0,   32'h0,  32'h0,  6'h22, 2'b00, 2'b00); step("r_sub");
      drive(0, 0, 0, 4'd2, 32'h50, 32'h1,  5'd1, 5'd3, 32'h100, 32'h0,  32'h0,  6'h00, 2'b00, 2'b00); step("r_sll");
      drive(0, 0, 0, 4'd3, 32'h50, 32'h60, 5'd1, 5'd3, 32'h0,   32'h80, 32'h70, 6'h00, 2'b01, 2'b10); step("and_fwd");
      drive(1, 0, 0, 4'd6, 32'h0,  32'h0,  5'd0, 5'd4, 32'h1234, 32'h0, 32'h0,  6'h00, 2'b00, 2'b00); step("lui");
      drive(0, 0, 0, 4'd7, 32'hFFFFFFFF, 32'h1, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 6'h00, 2'b11, 2'b11); step("slt");
      drive(0, 0, 0, 4'd8, 32'hFFFFFFFF, 32'h1, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 6'h00, 2'b00, 2'b00); step("sltu");
      drive(0, 0, 0, 4'd9, 32'h7,  32'h9,  5'd0, 5'd6, 32'h0,   32'h0,  32'h0,  6'h00, 2'b00, 2'b00); step("op_undef");
      drive(0, 0, 0, 4'd2, 32'h7,  32'h9,  5'd0, 5'd6, 32'h0,   32'h0,  32'h0,  6'h3F, 2'b00, 2'b00); step("fn_undef");
      drive(0, 0, 0, 4'd2, 32'h3,  32'h80000000, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 6'h07, 2'b00, 2'b00); step("srav");
      drive(0, 0, 0, 4'd0, 32'hFFFFFFFF, 32'h1, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 6'h00, 2'b00, 2'b00); step("wrap");

      for (int i = 0; i < 40; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 9)), $urandom, $urandom, 5'($urandom), 5'($urandom),
               $urandom, $urandom, $urandom, functs[$urandom_range(0, 15)],
               2'($urandom), 2'($urandom));
         step("rand");
      end

      drive(0, 1, 0, 4'd4, 32'h0F, 32'hF0, 5'd9, 5'd2, 32'h0, 32'h0, 32'h0, 6'h00, 2'b00, 2'b00);
      step("pre_rst");
      @(negedge i_clk);
      #2 i_rst = 1'b1;
      #1 check_zero("rst_mid");
      @(negedge i_clk);
      i_rst = 1'b0;
      drive(0, 0, 0, 4'd5, 32'hF0F0, 32'h0FF0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h0, 6'h00, 2'b00, 2'b00);
      step("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
